// File: rtl/ram_dma_pkg.sv
// Shared core defines for the RAM copy/fill initiator: write-enable levels, zero word, FSM encoding.
// No logic of its own; imported by the interface and the top.
// Word addresses are byte addresses with the two low bits clear.
package ram_dma_pkg;

  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Byte address of word idx counted from base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/ram_dma_if.sv
// RAM port bundle between the copy/fill initiator and the on-chip word RAM.
// Read data is combinational from the read address, so no handshake exists here.
// master = initiator side, slave = RAM side.
interface ram_dma_if;

  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_we_o,
    output mem_waddr_o,
    output mem_wdata_o,
    output mem_raddr_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_we_o,
    input  mem_waddr_o,
    input  mem_wdata_o,
    input  mem_raddr_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/ram_dma.sv
// Purpose: copies LEN words RAM-to-RAM or fills a region with a constant, one word per granted cycle.
// Latency: first write one cycle after busy rises; done_o two cycles after the last read issue with gnt held.
// Backpressure: gnt_i=0 freezes indices and the data register; abort_i ends the transfer with no further writes.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      fill_data_i,
  input  logic             abort_i,
  input  logic             gnt_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  ram_dma_if.master        mem
);

  state_t           state_q;
  state_t           state_d;
  logic             mode_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      fill_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_idx_q;
  logic [LEN_W-1:0] wr_idx_q;
  logic             v_q;
  logic             done_q;
  logic             err_q;

  logic             cmd_aligned;
  logic             cmd_accept;
  logic             active;
  logic             rd_fire;
  logic             wr_fire;
  logic             last_rd;

  // Command decode and per-cycle read/write firing; abort overrides grant.
  always_comb begin
    cmd_aligned = (src_addr_i[1:0] == 2'b00) && (dst_addr_i[1:0] == 2'b00);
    cmd_accept  = (state_q == ST_IDLE) && start_i && cmd_aligned && (len_i != '0);
    active      = (state_q != ST_IDLE);
    rd_fire     = (state_q == ST_RUN) && gnt_i && !abort_i;
    wr_fire     = active && v_q && gnt_i && !abort_i;
    last_rd     = (rd_idx_q == len_q - LEN_W'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: RUN issues reads until the last one, DRAIN retires the final write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_i) state_d = ST_IDLE;
        else if (rd_fire && last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_i || wr_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: status from registers, RAM port decoded from registered state plus grant/abort.
  always_comb begin
    busy_o          = active;
    done_o          = done_q;
    err_o           = err_q;
    words_done_o    = wr_idx_q;
    mem.mem_we_o    = wr_fire ? WriteEnable : WriteDisable;
    mem.mem_waddr_o = word_addr(dst_q, 32'(wr_idx_q));
    mem.mem_wdata_o = data_q;
    mem.mem_raddr_o = word_addr(src_q, 32'(rd_idx_q));
  end

  // Datapath: command latch, index counters, one-word data register and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= 1'b0;
      src_q    <= ZeroWord;
      dst_q    <= ZeroWord;
      fill_q   <= ZeroWord;
      data_q   <= ZeroWord;
      len_q    <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if ((state_q == ST_IDLE) && start_i) begin
        if (!cmd_aligned) begin
          err_q <= 1'b1;
        end else if (len_i == '0) begin
          done_q <= 1'b1;
        end else begin
          mode_q   <= mode_i;
          src_q    <= src_addr_i;
          dst_q    <= dst_addr_i;
          len_q    <= len_i;
          fill_q   <= fill_data_i;
          rd_idx_q <= '0;
          wr_idx_q <= '0;
          v_q      <= 1'b0;
        end
      end

      if (rd_fire) begin
        data_q   <= mode_q ? fill_q : mem.mem_rdata_i;
        rd_idx_q <= rd_idx_q + LEN_W'(1);
      end

      if (wr_fire) begin
        wr_idx_q <= wr_idx_q + LEN_W'(1);
      end

      // A read refills the slot even when the same cycle drained it.
      if (rd_fire) begin
        v_q <= 1'b1;
      end else if (wr_fire) begin
        v_q <= 1'b0;
      end

      if ((state_q == ST_DRAIN) && wr_fire) begin
        done_q <= 1'b1;
      end

      if (active && abort_i) begin
        v_q    <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

endmodule
